// File: rtl/wb_ext_responder.sv
// wb_ext_responder: Wishbone B3 slave terminating one external NoC master port.
// It holds a word-addressed local SRAM with byte-lane writes. It serves classic
// cycles and registered-feedback bursts (constant, linear, wrap-4/8/16). It
// answers out-of-window accesses with err and requests seen while busy with rty.
//
// Handshake: a request is wb_cyc_i & wb_stb_i. Exactly one of ack/err/rty
// terminates each accepted beat. The termination lasts one cycle. The master
// holds address, data, sel, cti and bte stable until it samples that termination.
// In a burst, ack follows stb combinationally. Read data for the next beat is
// prefetched from the slave's own address counter, so beats stream with no bubbles.
module wb_ext_responder #(
  parameter int unsigned     DW          = 32,
  parameter int unsigned     AW          = 32,
  parameter int unsigned     MEM_WORDS   = 1024,
  parameter logic [AW-1:0]   BASE_ADDR   = '0,
  parameter int unsigned     WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AW-1:0]     wb_adr_i,
  input  logic              wb_cyc_i,
  input  logic              wb_stb_i,
  input  logic              wb_we_i,
  input  logic [DW/8-1:0]   wb_sel_i,
  input  logic [DW-1:0]     wb_dat_i,
  input  logic              wb_cab_i,
  input  logic [2:0]        wb_cti_i,
  input  logic [1:0]        wb_bte_i,
  input  logic              stall_i,
  output logic              wb_ack_o,
  output logic              wb_err_o,
  output logic              wb_rty_o,
  output logic [DW-1:0]     wb_dat_o,
  output logic [2:0]        state_o
);

  localparam int IW = $clog2(MEM_WORDS);
  localparam int NB = DW / 8;
  localparam int WW = AW - 2;
  localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_WAIT        = 3'd1,
    S_CLASSIC_ACK = 3'd2,
    S_BURST       = 3'd3,
    S_TERM        = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      wcnt_q, wcnt_d;
  logic [WW-1:0]   word_q, word_d;
  logic            term_err_q, term_err_d;
  logic            term_rty_q, term_rty_d;
  logic [DW-1:0]   dat_q;
  logic [DW-1:0]   mem_q [MEM_WORDS];

  logic            req;
  logic [WW-1:0]   adr_word;
  logic [WW-1:0]   nxt_word;
  logic            cti_is_burst;
  logic            rd_en;
  logic [IW-1:0]   rd_idx;
  logic            mem_we;
  logic            ack_c;
  logic            err_c;

  // Byte-offset bits and the legacy burst hint carry no information here.
  logic unused_bits;
  assign unused_bits = ^{wb_cab_i, wb_adr_i[1:0]};

  // BASE_ADDR is aligned to the SRAM size, so the window test reduces to
  // comparing the word address bits above the SRAM index.
  function automatic logic in_window(input logic [WW-1:0] w);
    return w[WW-1:IW] == BASE_ADDR[AW-1:IW+2];
  endfunction

  // Address counter advance for one acked beat. Wrap modes keep the upper
  // bits and increment only the low 2/3/4 bits. Linear increments everything.
  function automatic logic [WW-1:0] next_word(input logic [WW-1:0] w,
                                              input logic [2:0]    cti,
                                              input logic [1:0]    bte);
    logic [WW-1:0] inc;
    logic [WW-1:0] mask;
    inc = w + WW'(1);
    unique case (bte)
      2'b01:   mask = WW'(4'h3);
      2'b10:   mask = WW'(4'h7);
      2'b11:   mask = WW'(4'hF);
      default: mask = '1;
    endcase
    if (cti == 3'b010) return (w & ~mask) | (inc & mask);
    return w;
  endfunction

  assign req          = wb_cyc_i & wb_stb_i;
  assign adr_word     = wb_adr_i[AW-1:2];
  assign nxt_word     = next_word(word_q, wb_cti_i, wb_bte_i);
  assign cti_is_burst = (wb_cti_i == 3'b001) || (wb_cti_i == 3'b010);

  // State, wait counter, address counter and pending err/rty flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      wcnt_q     <= 4'd0;
      word_q     <= '0;
      term_err_q <= 1'b0;
      term_rty_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      word_q     <= word_d;
      term_err_q <= term_err_d;
      term_rty_q <= term_rty_d;
    end
  end

  // Next-state logic, SRAM read/write strobes and combinational burst terminations.
  always_comb begin
    state_d    = state_q;
    wcnt_d     = wcnt_q;
    word_d     = word_q;
    term_err_d = term_err_q;
    term_rty_d = term_rty_q;
    rd_en      = 1'b0;
    rd_idx     = word_q[IW-1:0];
    mem_we     = 1'b0;
    ack_c      = 1'b0;
    err_c      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        term_err_d = 1'b0;
        term_rty_d = 1'b0;
        if (req) begin
          if (stall_i) begin
            state_d    = S_TERM;
            term_rty_d = 1'b1;
          end else if (!in_window(adr_word)) begin
            state_d    = S_TERM;
            term_err_d = 1'b1;
          end else begin
            word_d = adr_word;
            if (WAIT_STATES > 0) begin
              state_d = S_WAIT;
              wcnt_d  = WS_LOAD;
            end else begin
              state_d = cti_is_burst ? S_BURST : S_CLASSIC_ACK;
              rd_en   = 1'b1;
              rd_idx  = adr_word[IW-1:0];
            end
          end
        end
      end
      S_WAIT: begin
        if (!wb_cyc_i) begin
          state_d = S_IDLE;
        end else if (wcnt_q == 4'd0) begin
          state_d = cti_is_burst ? S_BURST : S_CLASSIC_ACK;
          rd_en   = 1'b1;
        end else begin
          wcnt_d = wcnt_q - 4'd1;
        end
      end
      S_CLASSIC_ACK: begin
        ack_c   = 1'b1;
        mem_we  = req & wb_we_i;
        state_d = S_IDLE;
      end
      S_BURST: begin
        if (!wb_cyc_i) begin
          state_d = S_IDLE;
        end else if (wb_stb_i) begin
          if (!in_window(word_q)) begin
            err_c   = 1'b1;
            state_d = S_IDLE;
          end else begin
            ack_c  = 1'b1;
            mem_we = wb_we_i;
            if (wb_cti_i == 3'b111) begin
              state_d = S_IDLE;
            end else begin
              word_d = nxt_word;
              // Prefetch the next beat only when it is a real SRAM word, so
              // wb_dat_o does not change ahead of an err beat.
              if (in_window(nxt_word)) begin
                rd_en  = 1'b1;
                rd_idx = nxt_word[IW-1:0];
              end
            end
          end
        end
      end
      S_TERM: begin
        term_err_d = 1'b0;
        term_rty_d = 1'b0;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // SRAM write port: byte lanes written only on an acked write beat.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int k = 0; k < NB; k++) begin
        if (wb_sel_i[k]) mem_q[word_q[IW-1:0]][8*k +: 8] <= wb_dat_i[8*k +: 8];
      end
    end
  end

  // SRAM read register: loaded just before each ack cycle, held otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dat_q <= '0;
    end else if (rd_en) begin
      dat_q <= mem_q[rd_idx];
    end
  end

  assign wb_ack_o = ack_c;
  assign wb_err_o = err_c | ((state_q == S_TERM) & term_err_q);
  assign wb_rty_o = (state_q == S_TERM) & term_rty_q;
  assign wb_dat_o = dat_q;
  assign state_o  = state_q;

endmodule

// File: tb/tb_wb_ext_responder.sv
// Directed bench for wb_ext_responder: dut0 (no wait states, window 0x0..0xFFF)
// and dut1 (3 wait states, 64 words at 0x1000) share one master bus.
module tb_wb_ext_responder;

  logic        clk;
  logic        rst;
  logic [31:0] adr;
  logic        cyc, stb, we, cab, stall;
  logic [3:0]  sel;
  logic [31:0] dat;
  logic [2:0]  cti;
  logic [1:0]  bte;

  logic        ack0, err0, rty0, ack1, err1, rty1;
  logic [31:0] dat0, dat1;
  logic [2:0]  st0, st1;
  logic        dsel;
  logic        m_ack, m_err, m_rty;
  logic [31:0] m_dat;

  int tests_run;
  int tests_failed;

  logic [31:0] wbuf [16];
  logic [31:0] rbuf [16];

  wb_ext_responder #(.DW(32), .AW(32), .MEM_WORDS(1024), .BASE_ADDR(32'h0000_0000),
                     .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst(rst), .wb_adr_i(adr), .wb_cyc_i(cyc), .wb_stb_i(stb),
    .wb_we_i(we), .wb_sel_i(sel), .wb_dat_i(dat), .wb_cab_i(cab), .wb_cti_i(cti),
    .wb_bte_i(bte), .stall_i(stall), .wb_ack_o(ack0), .wb_err_o(err0),
    .wb_rty_o(rty0), .wb_dat_o(dat0), .state_o(st0)
  );

  wb_ext_responder #(.DW(32), .AW(32), .MEM_WORDS(64), .BASE_ADDR(32'h0000_1000),
                     .WAIT_STATES(3)) dut1 (
    .clk(clk), .rst(rst), .wb_adr_i(adr), .wb_cyc_i(cyc), .wb_stb_i(stb),
    .wb_we_i(we), .wb_sel_i(sel), .wb_dat_i(dat), .wb_cab_i(cab), .wb_cti_i(cti),
    .wb_bte_i(bte), .stall_i(stall), .wb_ack_o(ack1), .wb_err_o(err1),
    .wb_rty_o(rty1), .wb_dat_o(dat1), .state_o(st1)
  );

  assign m_ack = dsel ? ack1 : ack0;
  assign m_err = dsel ? err1 : err0;
  assign m_rty = dsel ? rty1 : rty0;
  assign m_dat = dsel ? dat1 : dat0;

  // Clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One classic cycle; lat is the cycle index of the termination (0 = request cycle).
  task automatic classic_xfer(input logic [31:0] a, input logic w, input logic [3:0] s,
                              input logic [31:0] wd, output logic [31:0] rd,
                              output int lat, output int nack, output int nerr, output int nrty);
    bit done;
    nack = 0; nerr = 0; nrty = 0; lat = -1; rd = '0; done = 0;
    @(posedge clk); #1;
    adr = a; we = w; sel = s; dat = wd; cti = 3'b000; bte = 2'b00; cyc = 1'b1; stb = 1'b1;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      if (m_ack || m_err || m_rty) begin
        if (m_ack) nack++;
        if (m_err) nerr++;
        if (m_rty) nrty++;
        rd = m_dat; lat = c; done = 1;
      end
    end
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(negedge clk);
    if (m_ack) nack++;
    if (m_err) nerr++;
    if (m_rty) nrty++;
  endtask

  // Registered-feedback burst; write data from wbuf, read data into rbuf.
  // stb drops for gap_len cycles before beat gap_beat. span = cycles first..last ack.
  task automatic burst_xfer(input logic [31:0] a, input logic w, input logic [2:0] ck,
                            input logic [1:0] bk, input int nbeats, input int gap_beat,
                            input int gap_len, output int nack, output int nerr, output int span);
    int beat, ncyc, first, last, gap_left;
    bit done;
    beat = 0; ncyc = 0; first = -1; last = -2; gap_left = gap_len; done = 0;
    nack = 0; nerr = 0;
    @(posedge clk); #1;
    adr = a; we = w; sel = 4'hF; bte = bk; dat = wbuf[0];
    cti = (nbeats == 1) ? 3'b111 : ck; cyc = 1'b1; stb = 1'b1;
    while (!done && ncyc < 100) begin
      @(negedge clk);
      if (m_err) begin
        nerr++; done = 1;
      end else if (m_ack) begin
        rbuf[beat] = m_dat; nack++;
        if (first < 0) first = ncyc;
        last = ncyc; beat++;
        if (beat == nbeats) done = 1;
      end
      ncyc++;
      @(posedge clk); #1;
      if (!done) begin
        if (beat == gap_beat && gap_left > 0) begin
          stb = 1'b0; gap_left--;
        end else begin
          stb = 1'b1; dat = wbuf[beat];
          cti = (beat == nbeats - 1) ? 3'b111 : ck;
        end
      end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0; cti = 3'b000; bte = 2'b00;
    @(negedge clk);
    if (m_ack) nack++;
    if (m_err) nerr++;
    span = last - first + 1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests_run++; if ({ack0, err0, rty0} !== 3'b000) begin tests_failed++; $display("FAIL reset_terms: got %b expected 000", {ack0, err0, rty0}); end
    tests_run++; if (dat0 !== 32'h0) begin tests_failed++; $display("FAIL reset_dat: got %h expected 00000000", dat0); end
    tests_run++; if (st0 !== 3'd0 || st1 !== 3'd0) begin tests_failed++; $display("FAIL reset_state: got %0d/%0d expected 0/0", st0, st1); end
    tests_run++; if ({ack1, err1, rty1} !== 3'b000) begin tests_failed++; $display("FAIL reset_terms1: got %b expected 000", {ack1, err1, rty1}); end
    rst = 1'b1;
  endtask

  task automatic test_classic();
    logic [31:0] rd; int lat, na, ne, nr;
    dsel = 1'b0;
    classic_xfer(32'h10, 1'b1, 4'hF, 32'hDEADBEEF, rd, lat, na, ne, nr);
    tests_run++; if (lat !== 1 || na !== 1 || ne !== 0 || nr !== 0) begin tests_failed++; $display("FAIL classic_wr: got lat=%0d ack=%0d err=%0d rty=%0d expected 1/1/0/0", lat, na, ne, nr); end
    classic_xfer(32'h10, 1'b0, 4'hF, 32'h0, rd, lat, na, ne, nr);
    tests_run++; if (lat !== 1 || na !== 1 || ne !== 0 || nr !== 0) begin tests_failed++; $display("FAIL classic_rd: got lat=%0d ack=%0d err=%0d rty=%0d expected 1/1/0/0", lat, na, ne, nr); end
    tests_run++; if (rd !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL classic_rd_data: got %h expected deadbeef", rd); end
  endtask

  task automatic test_byte_lanes();
    logic [31:0] rd; int lat, na, ne, nr;
    dsel = 1'b0;
    classic_xfer(32'h20, 1'b1, 4'hF, 32'h0, rd, lat, na, ne, nr);
    classic_xfer(32'h20, 1'b1, 4'b0101, 32'h11223344, rd, lat, na, ne, nr);
    classic_xfer(32'h20, 1'b0, 4'hF, 32'h0, rd, lat, na, ne, nr);
    tests_run++; if (rd !== 32'h00220044) begin tests_failed++; $display("FAIL byte_lanes: got %h expected 00220044", rd); end
  endtask

  task automatic test_back_to_back();
    int a1, a2, nacks, extra;
    logic [31:0] d1, d2;
    dsel = 1'b0; a1 = -1; a2 = -1; nacks = 0; d1 = '0; d2 = '0;
    @(posedge clk); #1;
    adr = 32'h10; we = 1'b0; sel = 4'hF; cti = 3'b000; bte = 2'b00; cyc = 1'b1; stb = 1'b1;
    for (int c = 0; c < 12 && nacks < 2; c++) begin
      @(negedge clk);
      if (m_ack) begin
        nacks++;
        if (nacks == 1) begin a1 = c; d1 = m_dat; end
        else begin a2 = c; d2 = m_dat; end
      end
      @(posedge clk); #1;
      if (nacks == 1 && c == a1) adr = 32'h20;
    end
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    extra = m_ack ? 1 : 0;
    tests_run++; if (a1 !== 1 || a2 !== 3 || extra !== 0) begin tests_failed++; $display("FAIL b2b_timing: got acks at %0d,%0d trailing=%0d expected 1,3 trailing=0", a1, a2, extra); end
    tests_run++; if (d1 !== 32'hDEADBEEF || d2 !== 32'h00220044) begin tests_failed++; $display("FAIL b2b_data: got %h,%h expected deadbeef,00220044", d1, d2); end
  endtask

  task automatic test_wrap4();
    logic [31:0] rd; int lat, na, ne, nr, span;
    logic [31:0] pre [4];
    dsel = 1'b0;
    pre[0] = 32'hAAAA_000A; pre[1] = 32'hBBBB_000B; pre[2] = 32'hCCCC_000C; pre[3] = 32'hDDDD_000D;
    for (int i = 0; i < 4; i++) classic_xfer(32'h30 + 32'(4 * i), 1'b1, 4'hF, pre[i], rd, lat, na, ne, nr);
    burst_xfer(32'h38, 1'b0, 3'b010, 2'b01, 4, -1, 0, na, ne, span);
    tests_run++; if (na !== 4 || ne !== 0 || span !== 4) begin tests_failed++; $display("FAIL wrap4_acks: got ack=%0d err=%0d span=%0d expected 4/0/4", na, ne, span); end
    tests_run++; if (rbuf[0] !== 32'hCCCC_000C || rbuf[1] !== 32'hDDDD_000D || rbuf[2] !== 32'hAAAA_000A || rbuf[3] !== 32'hBBBB_000B) begin
      tests_failed++; $display("FAIL wrap4_data: got %h %h %h %h expected C D A B", rbuf[0], rbuf[1], rbuf[2], rbuf[3]);
    end
  endtask

  task automatic test_linear_gap();
    logic [31:0] rd; int lat, na, ne, nr, span;
    dsel = 1'b0;
    for (int i = 0; i < 8; i++) wbuf[i] = 32'hC0DE_0000 + 32'(i);
    burst_xfer(32'h0, 1'b1, 3'b010, 2'b00, 8, 4, 2, na, ne, span);
    tests_run++; if (na !== 8 || ne !== 0 || span !== 10) begin tests_failed++; $display("FAIL linear_gap_acks: got ack=%0d err=%0d span=%0d expected 8/0/10", na, ne, span); end
    for (int i = 0; i < 8; i++) begin
      classic_xfer(32'(4 * i), 1'b0, 4'hF, 32'h0, rd, lat, na, ne, nr);
      tests_run++; if (rd !== 32'hC0DE_0000 + 32'(i)) begin tests_failed++; $display("FAIL linear_word%0d: got %h expected %h", i, rd, 32'hC0DE_0000 + 32'(i)); end
    end
  endtask

  task automatic test_err();
    logic [31:0] rd; int lat, na, ne, nr, span;
    dsel = 1'b0;
    classic_xfer(32'h1000, 1'b1, 4'hF, 32'hBAD0BAD0, rd, lat, na, ne, nr);
    tests_run++; if (lat !== 1 || na !== 0 || ne !== 1 || nr !== 0) begin tests_failed++; $display("FAIL err_window: got lat=%0d ack=%0d err=%0d rty=%0d expected 1/0/1/0", lat, na, ne, nr); end
    classic_xfer(32'h0, 1'b0, 4'hF, 32'h0, rd, lat, na, ne, nr);
    tests_run++; if (rd !== 32'hC0DE_0000) begin tests_failed++; $display("FAIL err_sram_unchanged: got %h expected c0de0000", rd); end
    // Linear burst from word 1022: two beats in window, the third runs off the end.
    burst_xfer(32'hFF8, 1'b0, 3'b010, 2'b00, 3, -1, 0, na, ne, span);
    tests_run++; if (na !== 2 || ne !== 1) begin tests_failed++; $display("FAIL burst_err: got ack=%0d err=%0d expected 2/1", na, ne); end
  endtask

  task automatic test_stall();
    logic [31:0] rd; int lat, na, ne, nr;
    dsel = 1'b0;
    stall = 1'b1;
    classic_xfer(32'h10, 1'b0, 4'hF, 32'h0, rd, lat, na, ne, nr);
    stall = 1'b0;
    tests_run++; if (lat !== 1 || na !== 0 || ne !== 0 || nr !== 1) begin tests_failed++; $display("FAIL stall_rty: got lat=%0d ack=%0d err=%0d rty=%0d expected 1/0/0/1", lat, na, ne, nr); end
  endtask

  task automatic test_wait_states();
    logic [31:0] rd; int lat, na, ne, nr, terms;
    dsel = 1'b1;
    classic_xfer(32'h1004, 1'b1, 4'hF, 32'h5A5A_1234, rd, lat, na, ne, nr);
    tests_run++; if (lat !== 4 || na !== 1 || ne !== 0 || nr !== 0) begin tests_failed++; $display("FAIL ws_write: got lat=%0d ack=%0d err=%0d rty=%0d expected 4/1/0/0", lat, na, ne, nr); end
    classic_xfer(32'h1004, 1'b0, 4'hF, 32'h0, rd, lat, na, ne, nr);
    tests_run++; if (lat !== 4 || na !== 1 || rd !== 32'h5A5A_1234) begin tests_failed++; $display("FAIL ws_read: got lat=%0d ack=%0d data=%h expected 4/1/5a5a1234", lat, na, rd); end
    // Abandon the cycle while the slave is still counting wait states.
    terms = 0;
    @(posedge clk); #1;
    adr = 32'h1008; we = 1'b0; cti = 3'b000; cyc = 1'b1; stb = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (ack1 || err1 || rty1) terms++;
    end
    tests_run++; if (terms !== 0 || st1 !== 3'd0) begin tests_failed++; $display("FAIL ws_abandon: got terms=%0d state=%0d expected 0/0", terms, st1); end
    classic_xfer(32'h1004, 1'b0, 4'hF, 32'h0, rd, lat, na, ne, nr);
    tests_run++; if (lat !== 4 || rd !== 32'h5A5A_1234) begin tests_failed++; $display("FAIL ws_after_abandon: got lat=%0d data=%h expected 4/5a5a1234", lat, rd); end
  endtask

  task automatic test_reset_mid_burst();
    logic [31:0] rd; int lat, na, ne, nr, nacks;
    dsel = 1'b0; nacks = 0;
    @(posedge clk); #1;
    adr = 32'h0; we = 1'b0; sel = 4'hF; cti = 3'b010; bte = 2'b00; cyc = 1'b1; stb = 1'b1;
    for (int c = 0; c < 10 && nacks < 2; c++) begin
      @(negedge clk);
      if (ack0) nacks++;
    end
    #1 rst = 1'b0;
    #1;
    tests_run++; if (nacks !== 2 || ack0 !== 1'b0 || st0 !== 3'd0) begin tests_failed++; $display("FAIL rst_mid_burst: got acks=%0d ack=%b state=%0d expected 2/0/0", nacks, ack0, st0); end
    tests_run++; if (dat0 !== 32'h0) begin tests_failed++; $display("FAIL rst_mid_burst_dat: got %h expected 00000000", dat0); end
    cyc = 1'b0; stb = 1'b0; cti = 3'b000;
    @(posedge clk); #1 rst = 1'b1;
    classic_xfer(32'h0, 1'b0, 4'hF, 32'h0, rd, lat, na, ne, nr);
    tests_run++; if (lat !== 1 || na !== 1 || rd !== 32'hC0DE_0000) begin tests_failed++; $display("FAIL rst_then_read: got lat=%0d ack=%0d data=%h expected 1/1/c0de0000", lat, na, rd); end
  endtask

  // Sequencer.
  initial begin
    tests_run = 0; tests_failed = 0;
    rst = 1'b0; adr = '0; cyc = 1'b0; stb = 1'b0; we = 1'b0; cab = 1'b0; stall = 1'b0;
    sel = 4'h0; dat = '0; cti = 3'b000; bte = 2'b00; dsel = 1'b0;
    for (int i = 0; i < 16; i++) begin wbuf[i] = '0; rbuf[i] = '0; end
    test_reset();
    test_classic();
    test_byte_lanes();
    test_back_to_back();
    test_wrap4();
    test_linear_gap();
    test_err();
    test_stall();
    test_wait_states();
    test_reset_mid_burst();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
